// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM states, bus phase encodings and the
// select-width helper used by the master and the address decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic PENABLE_SETUP  = 1'b0;
  localparam logic PENABLE_ACCESS = 1'b1;

  // A single slave still needs one index bit so the address slice is legal.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/apb_decoder.sv
// Combinational address decoder: top address bits to a one-hot slave select,
// flagging indices that have no slave behind them.
module apb_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  dec_err_o
);

  logic [SEL_W-1:0] idx;

  assign idx = addr_i[ADDR_W-1 -: SEL_W];

  always_comb begin
    sel_o     = '0;
    dec_err_o = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SEL_W'(i)) begin
        sel_o[i]  = 1'b1;
        dec_err_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB4 master: takes one command at a time, runs it on a shared bus with one
// select line per slave, and returns a single-cycle completion.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                         P_clk,
  input  logic                         P_reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  input  logic [DATA_W/8-1:0]          cmd_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        P_sel,
  output logic                         P_enable,
  output logic                         P_write,
  output logic [ADDR_W-1:0]            P_addr,
  output logic [DATA_W-1:0]            P_wdata,
  output logic [DATA_W/8-1:0]          P_strb,
  input  logic [NUM_SLAVES*DATA_W-1:0] P_rdata,
  input  logic [NUM_SLAVES-1:0]        P_ready,
  input  logic [NUM_SLAVES-1:0]        P_slverr
);

  localparam int SEL_W  = sel_width(NUM_SLAVES);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) + 1 : 1;

  apb_state_e              state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    write_q, write_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]       strb_q, strb_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_err;
  logic                    rdy_sel;
  logic                    slverr_sel;
  logic [DATA_W-1:0]       rdata_sel;

  apb_decoder #(
    .ADDR_W    (ADDR_W),
    .NUM_SLAVES(NUM_SLAVES),
    .SEL_W     (SEL_W)
  ) u_decoder (
    .addr_i   (cmd_addr),
    .sel_o    (dec_sel),
    .dec_err_o(dec_err)
  );

  // Only the slave picked at acceptance is listened to; sel_q is one-hot.
  always_comb begin
    rdy_sel    = 1'b0;
    slverr_sel = 1'b0;
    rdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        rdy_sel    = P_ready[i];
        slverr_sel = P_slverr[i];
        rdata_sel  = P_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge P_clk) begin
    if (P_reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          strb_d  = cmd_write ? cmd_strb : '0;
          sel_d   = dec_sel;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = dec_err;
          state_d = dec_err ? RESP : SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A ready slave wins over a timeout landing on the same cycle.
        if (rdy_sel) begin
          err_d   = slverr_sel;
          rdata_d = (!write_q && !slverr_sel) ? rdata_sel : '0;
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_d == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE) && !P_reset;
    P_sel     = '0;
    P_enable  = PENABLE_SETUP;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state_q)
      SETUP:  P_sel = sel_q;
      ACCESS: begin
        P_sel    = sel_q;
        P_enable = PENABLE_ACCESS;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign P_write = write_q;
  assign P_addr  = addr_q;
  assign P_wdata = wdata_q;
  assign P_strb  = strb_q;

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench for apb_master_mux: a transaction-timeline model checked on
// every cycle, plus literal expectations for each scenario.
module tb_apb_master_mux;

  localparam int TO = 4;
  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        dec_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [0:0]  cmd_strb = '0;
  logic [31:0] p_rdata = '0;
  logic [3:0]  p_ready = '0;
  logic [3:0]  p_slverr = '0;

  logic       a_ready, a_rv, a_err, a_en, a_pw;
  logic [7:0] a_rdata, a_paddr, a_pwdata;
  logic [0:0] a_pstrb;
  logic [3:0] a_sel;

  logic       b_ready, b_rv, b_err, b_en, b_pw;
  logic [7:0] b_rdata, b_paddr, b_pwdata;
  logic [0:0] b_pstrb;
  logic [2:0] b_sel;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  apb_master_mux #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(4), .TIMEOUT(TO)) u_dut (
    .P_clk(clk), .P_reset(rst), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err),
    .P_sel(a_sel), .P_enable(a_en), .P_write(a_pw), .P_addr(a_paddr),
    .P_wdata(a_pwdata), .P_strb(a_pstrb),
    .P_rdata(p_rdata), .P_ready(p_ready), .P_slverr(p_slverr)
  );

  apb_master_mux #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT(TO)) u_dut3 (
    .P_clk(clk), .P_reset(rst), .cmd_valid(dec_valid), .cmd_ready(b_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err),
    .P_sel(b_sel), .P_enable(b_en), .P_write(b_pw), .P_addr(b_paddr),
    .P_wdata(b_pwdata), .P_strb(b_pstrb),
    .P_rdata(p_rdata[23:0]), .P_ready(p_ready[2:0]), .P_slverr(p_slverr[2:0])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: DUT did not respond within the cycle bound (t=%0t)", name, $time);
  endtask

  // Model: a transfer is a timeline counted in cycles after its acceptance
  // edge k; phase 1 is setup, phases 2.. are access, end_off is the response.
  int         e = 0;
  int         k = 0;
  bit         m_act = 1'b0;
  bit         m_dec = 1'b0;
  int         m_idx = 0;
  int         end_off = -1;
  logic [7:0] m_rdata = '0;
  logic       m_err = 1'b0;
  logic [7:0] h_addr = '0, h_wdata = '0;
  logic       h_wr = 1'b0;
  logic [0:0] h_strb = '0;

  always @(posedge clk) begin
    int pp;
    e++;
    if (rst) begin
      m_act = 1'b0; h_addr = '0; h_wdata = '0; h_wr = 1'b0; h_strb = '0;
    end else if (m_act) begin
      pp = e - k;
      if (end_off < 0 && pp >= 2) begin
        if (p_ready[m_idx]) begin
          end_off = pp + 1;
          m_err   = p_slverr[m_idx];
          m_rdata = (!h_wr && !m_err) ? p_rdata[m_idx*8 +: 8] : 8'h00;
        end else if (TO != 0 && pp - 1 == TO) begin
          end_off = pp + 1;
          m_err   = 1'b1;
          m_rdata = 8'h00;
        end
      end
      if (pp == end_off) m_act = 1'b0;
    end else if (cmd_valid) begin
      k = e; m_act = 1'b1;
      m_idx = int'(cmd_addr[7:6]);
      m_dec = (m_idx >= NS);
      h_addr = cmd_addr; h_wr = cmd_write; h_wdata = cmd_wdata;
      h_strb = cmd_write ? cmd_strb : 1'b0;
      if (m_dec) begin end_off = 1; m_err = 1'b1; m_rdata = 8'h00; end
      else end_off = -1;
    end
  end

  always @(negedge clk) begin
    int p;
    logic [3:0] esel;
    logic       een, erv, eer;
    logic [7:0] erd;
    if (chk_en) begin
      p = e - k + 1;
      esel = '0; een = 1'b0; erv = 1'b0; eer = 1'b0; erd = '0;
      if (m_act) begin
        if (!m_dec && p >= 1 && (end_off < 0 || p < end_off)) begin
          esel = 4'b0001 << m_idx;
          een  = (p >= 2);
        end
        if (p == end_off) begin erv = 1'b1; erd = m_rdata; eer = m_err; end
      end
      chk("cmd_ready", 32'(a_ready), 32'(!m_act && !rst));
      chk("P_sel", 32'(a_sel), 32'(esel));
      chk("P_enable", 32'(a_en), 32'(een));
      chk("rsp_valid", 32'(a_rv), 32'(erv));
      chk("rsp_rdata", 32'(a_rdata), 32'(erd));
      chk("rsp_err", 32'(a_err), 32'(eer));
      chk("P_addr", 32'(a_paddr), 32'(h_addr));
      chk("P_write", 32'(a_pw), 32'(h_wr));
      chk("P_wdata", 32'(a_pwdata), 32'(h_wdata));
      chk("P_strb", 32'(a_pstrb), 32'(h_strb));
    end
  end

  task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                          input logic st);
    int n = 0;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st; cmd_valid = 1'b1;
    while (a_ready !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    if (n >= 20) fail_bound("accept");
    @(posedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic slaves_cfg(input int sidx, input logic serr, input logic [7:0] rd);
    p_ready = 4'hF; p_slverr = 4'hF;
    for (int i = 0; i < 4; i++) p_rdata[i*8 +: 8] = 8'hA0 | 8'(i);
    p_ready[sidx] = 1'b0; p_slverr[sidx] = serr; p_rdata[sidx*8 +: 8] = rd;
  endtask

  task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                         input logic st, input int sidx, input int waits, input logic serr,
                         input logic [7:0] rd, input int exp_lat, input logic [7:0] exp_rd,
                         input logic exp_err, input logic [3:0] exp_sel);
    int lat = 1;
    int acc = 0;
    bit seen = 1'b0;
    slaves_cfg(sidx, serr, rd);
    send_cmd(wr, addr, wd, st);
    chk("setup_sel", 32'(a_sel), 32'(exp_sel));
    chk("setup_enable", 32'(a_en), 32'(0));
    chk("setup_strb", 32'(a_pstrb), 32'(wr ? st : 1'b0));
    while (!seen && lat < 40) begin
      if (a_rv === 1'b1) begin
        seen = 1'b1;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_rdata", 32'(a_rdata), 32'(exp_rd));
        chk("resp_err", 32'(a_err), 32'(exp_err));
        chk("resp_sel_low", 32'(a_sel), 32'(0));
      end else begin
        if (a_en === 1'b1) begin
          acc++;
          p_ready[sidx] = (acc > waits);
        end else p_ready[sidx] = 1'b0;
        @(posedge clk); #2;
        lat++;
      end
    end
    if (!seen) fail_bound("response");
    p_ready[sidx] = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("b_ready_in_reset", 32'(b_ready), 32'(0));
    #1 rst = 1'b0;
    @(posedge clk); #2;
    chk("b_ready_after_reset", 32'(b_ready), 32'(1));

    // write, zero wait, slave 1
    run_cmd(1'b1, 8'h45, 8'hA5, 1'b1, 1, 0, 1'b0, 8'h99, 3, 8'h00, 1'b0, 4'b0010);
    // read, 3 waits, slave 3; ready coincides with the timeout count
    run_cmd(1'b0, 8'hC2, 8'h11, 1'b1, 3, 3, 1'b0, 8'h3C, 6, 8'h3C, 1'b0, 4'b1000);
    // slave error on read, slave 0
    run_cmd(1'b0, 8'h10, 8'h00, 1'b0, 0, 0, 1'b1, 8'hFF, 3, 8'h00, 1'b1, 4'b0001);
    // timeout, slave 1 never ready
    run_cmd(1'b0, 8'h50, 8'h00, 1'b0, 1, 100, 1'b0, 8'h66, 6, 8'h00, 1'b1, 4'b0010);
    // write with 2 waits, slave 2
    run_cmd(1'b1, 8'h8F, 8'h3E, 1'b1, 2, 2, 1'b0, 8'h12, 5, 8'h00, 1'b0, 4'b0100);

    // decode error on the three-slave instance
    cmd_write = 1'b0; cmd_addr = 8'hC0; dec_valid = 1'b1; n = 0;
    while (b_ready !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    if (n >= 20) fail_bound("dec_accept");
    @(posedge clk); #2;
    dec_valid = 1'b0;
    chk("dec_rsp_valid", 32'(b_rv), 32'(1));
    chk("dec_rsp_err", 32'(b_err), 32'(1));
    chk("dec_rsp_rdata", 32'(b_rdata), 32'(0));
    chk("dec_sel", 32'(b_sel), 32'(0));
    chk("dec_enable", 32'(b_en), 32'(0));
    chk("dec_addr", 32'(b_paddr), 32'(8'hC0));
    @(posedge clk); #2;
    chk("dec_rsp_once", 32'(b_rv), 32'(0));
    chk("dec_sel_after", 32'(b_sel), 32'(0));
    chk("dec_ready_back", 32'(b_ready), 32'(1));

    // reset during access wait states, slave 2
    slaves_cfg(2, 1'b0, 8'h77);
    send_cmd(1'b0, 8'h81, 8'h00, 1'b0);
    repeat (2) begin @(posedge clk); #2; end
    chk("pre_reset_enable", 32'(a_en), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_sel", 32'(a_sel), 32'(0));
    chk("rst_enable", 32'(a_en), 32'(0));
    chk("rst_addr", 32'(a_paddr), 32'(0));
    chk("rst_cmd_ready", 32'(a_ready), 32'(0));
    chk("rst_rsp_valid", 32'(a_rv), 32'(0));
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("no_rsp_after_reset", 32'(a_rv), 32'(0));
      @(posedge clk); #2;
    end
    run_cmd(1'b0, 8'h81, 8'h00, 1'b0, 2, 0, 1'b0, 8'h77, 3, 8'h77, 1'b0, 4'b0100);

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
